// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit and receive paths: the frame
// state encoding, the parity type constants and the idle line level.
// No ports; imported with "import uart_pkg::*;".

package uart_pkg;

  // Frame states, 3-bit binary encoded.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Parity type as carried in REG2[1].
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Level of the serial line between frames and during stop bits.
  localparam logic LINE_IDLE = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_parity_calc.sv
// uart_parity_calc
// Combinational parity generator shared by the transmitter and the
// receiver's parity checker.
// Ports:
//   data     in  DW  data word to protect
//   par_typ  in  1   PAR_EVEN (0) or PAR_ODD (1)
//   par_bit  out 1   parity bit to send (or to compare against)

module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] data,
  input  logic          par_typ,
  output logic          par_bit
);

  // Even parity makes the total count of ones even, so the bit equals the
  // XOR of the data; odd parity is its complement.
  always_comb begin
    par_bit = ^data;
    if (par_typ == PAR_ODD) begin
      par_bit = ~^data;
    end
  end

endmodule : uart_parity_calc

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Serializing UART transmitter. Pops one byte from the TX FIFO and sends a
// start / DW data (LSB first) / optional parity / stop frame, one bit per
// TX_clk cycle. Back-to-back frames leave no idle bit between them.
// Ports:
//   TX_clk      in  1   bit-rate clock, rising edge
//   TX_rst      in  1   asynchronous active-high reset
//   P_DATA      in  DW  byte at the FIFO read port
//   Data_Valid  in  1   FIFO not empty (synchronized to TX_clk)
//   PAR_EN      in  1   parity enable (REG2[0])
//   PAR_TYP     in  1   0 = even, 1 = odd (REG2[1])
//   rd_inc      out 1   FIFO pop strobe, high in the accepting cycle
//   TX_OUT      out 1   serial line, idles high
//   busy        out 1   high while a frame is on the line
//   frame_done  out 1   high during the stop-bit cycle

module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          TX_clk,
  input  logic          TX_rst,
  input  logic [DW-1:0] P_DATA,
  input  logic          Data_Valid,
  input  logic          PAR_EN,
  input  logic          PAR_TYP,
  output logic          rd_inc,
  output logic          TX_OUT,
  output logic          busy,
  output logic          frame_done
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  tx_state_t     state;
  tx_state_t     next_state;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] data_q;
  logic          par_en_q;
  logic          par_bit_q;
  logic          par_bit_new;
  logic          accept;

  uart_parity_calc #(.DW(DW)) u_parity (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_bit_new)
  );

  // A byte is taken only from IDLE or from the stop bit, which lets a
  // waiting byte follow the stop bit with no gap.
  assign accept = ((state == IDLE) || (state == STOP)) && Data_Valid;

  always_ff @(posedge TX_clk or posedge TX_rst) begin
    if (TX_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Data_Valid) next_state = START;
      START:   next_state = DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
          next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY:  next_state = STOP;
      STOP:    next_state = Data_Valid ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Data and configuration are captured together at acceptance so that
  // register writes during a frame only affect later frames. Parity is
  // computed from the incoming byte here rather than from data_q later.
  always_ff @(posedge TX_clk or posedge TX_rst) begin
    if (TX_rst) begin
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_bit_q <= par_bit_new;
      end
      if (state == START) begin
        bit_cnt <= '0;
      end else if (state == DATA) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // Line level and flags decode from registered state; only the pop
  // strobe also looks at Data_Valid so the pop lands in the accepting cycle.
  always_comb begin
    TX_OUT     = LINE_IDLE;
    busy       = 1'b1;
    frame_done = 1'b0;
    rd_inc     = accept;
    case (state)
      IDLE:    busy = 1'b0;
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = data_q[bit_cnt];
      PARITY:  TX_OUT = par_bit_q;
      STOP:    frame_done = 1'b1;
      default: begin
        busy   = 1'b0;
        rd_inc = 1'b0;
      end
    endcase
  end

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
// Directed self-checking bench for uart_tx_frame: a table of single frames
// followed by hand-written back-to-back, config-change, reset and idle runs.

module tb_uart_tx_frame;
  import uart_pkg::*;

  logic       TX_clk;
  logic       TX_rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       rd_inc;
  logic       TX_OUT;
  logic       busy;
  logic       frame_done;

  int checks;
  int fails;

  // Expected line bits: bit i is the level in frame cycle i.
  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_typ;
    logic [10:0] line;
    int          len;
  } vec_t;

  vec_t vecs[7];

  uart_tx_frame #(.DW(8)) dut (
    .TX_clk     (TX_clk),
    .TX_rst     (TX_rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .rd_inc     (rd_inc),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial TX_clk = 1'b0;
  always #5 TX_clk = ~TX_clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Starts and ends just after a rising edge with the DUT idle. Offers one
  // byte, then follows the whole frame. toggle_at flips PAR_EN in that
  // frame cycle (-1 for never).
  task automatic applyStimulus(input logic [7:0] data, input logic en, input logic typ,
                               input logic [10:0] line, input int len, input int toggle_at);
    P_DATA     = data;
    PAR_EN     = en;
    PAR_TYP    = typ;
    Data_Valid = 1'b1;
    @(negedge TX_clk);
    checkOutput("accept_rd_inc", rd_inc, 1'b1);
    checkOutput("accept_busy", busy, 1'b0);
    checkOutput("accept_line", TX_OUT, 1'b1);
    @(posedge TX_clk); #1;
    Data_Valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == toggle_at) PAR_EN = ~PAR_EN;
      @(negedge TX_clk);
      checkOutput($sformatf("line[%0d]", i), TX_OUT, line[i]);
      checkOutput($sformatf("busy[%0d]", i), busy, 1'b1);
      checkOutput($sformatf("frame_done[%0d]", i), frame_done, (i == len - 1));
      checkOutput($sformatf("rd_inc[%0d]", i), rd_inc, 1'b0);
      @(posedge TX_clk); #1;
    end
    @(negedge TX_clk);
    checkOutput("after_busy", busy, 1'b0);
    checkOutput("after_line", TX_OUT, 1'b1);
    checkOutput("after_frame_done", frame_done, 1'b0);
    @(posedge TX_clk); #1;
  endtask

  initial begin
    int pops;
    logic [10:0] f1;
    logic [10:0] f2;
    checks = 0;
    fails  = 0;

    vecs[0] = '{8'h12, 1'b0, 1'b0, {1'b0, 1'b1, 8'h12, 1'b0}, 10};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, {1'b1, 1'b0, 8'hFF, 1'b0}, 11};
    vecs[2] = '{8'h12, 1'b1, 1'b1, {1'b1, 1'b1, 8'h12, 1'b0}, 11};
    vecs[3] = '{8'h00, 1'b1, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 11};
    vecs[4] = '{8'h07, 1'b1, 1'b0, {1'b1, 1'b1, 8'h07, 1'b0}, 11};
    vecs[5] = '{8'h07, 1'b1, 1'b1, {1'b1, 1'b0, 8'h07, 1'b0}, 11};
    vecs[6] = '{8'hC3, 1'b0, 1'b1, {1'b0, 1'b1, 8'hC3, 1'b0}, 10};

    TX_rst     = 1'b1;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    #12;
    checkOutput("reset_line", TX_OUT, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rd_inc", rd_inc, 1'b0);
    checkOutput("reset_frame_done", frame_done, 1'b0);
    @(posedge TX_clk); #1;
    TX_rst = 1'b0;
    @(posedge TX_clk); #1;

    $display("[TB] table-driven frames");
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].data, vecs[v].par_en, vecs[v].par_typ, vecs[v].line, vecs[v].len, -1);
    end

    // Back-to-back: AA then 55, both even parity (parity bit 0 for each).
    $display("[TB] back-to-back frames");
    f1 = {1'b1, 1'b0, 8'hAA, 1'b0};
    f2 = {1'b1, 1'b0, 8'h55, 1'b0};
    pops = 0;
    P_DATA = 8'hAA; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge TX_clk);
    checkOutput("b2b_first_pop", rd_inc, 1'b1);
    if (rd_inc) pops++;
    @(posedge TX_clk); #1;
    P_DATA = 8'h55;
    for (int i = 0; i < 11; i++) begin
      @(negedge TX_clk);
      checkOutput($sformatf("b2b1_line[%0d]", i), TX_OUT, f1[i]);
      checkOutput($sformatf("b2b1_busy[%0d]", i), busy, 1'b1);
      checkOutput($sformatf("b2b1_rd_inc[%0d]", i), rd_inc, (i == 10));
      checkOutput($sformatf("b2b1_done[%0d]", i), frame_done, (i == 10));
      if (rd_inc) pops++;
      @(posedge TX_clk); #1;
    end
    Data_Valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge TX_clk);
      checkOutput($sformatf("b2b2_line[%0d]", i), TX_OUT, f2[i]);
      checkOutput($sformatf("b2b2_busy[%0d]", i), busy, 1'b1);
      checkOutput($sformatf("b2b2_rd_inc[%0d]", i), rd_inc, 1'b0);
      if (rd_inc) pops++;
      @(posedge TX_clk); #1;
    end
    @(negedge TX_clk);
    checkOutput("b2b_idle_busy", busy, 1'b0);
    checkOutput("b2b_pop_count_is_2", (pops == 2), 1'b1);
    @(posedge TX_clk); #1;

    // PAR_EN raised during the data bits: that frame stays 10 cycles.
    $display("[TB] config change mid-frame");
    applyStimulus(8'h3C, 1'b0, 1'b0, {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 4);
    checkOutput("par_en_still_high", PAR_EN, 1'b1);
    applyStimulus(8'h3C, PAR_EN, 1'b0, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1);

    // Reset during DATA bit 4 of F0.
    $display("[TB] reset mid-frame");
    P_DATA = 8'hF0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge TX_clk);
    checkOutput("rst_pre_rd_inc", rd_inc, 1'b1);
    @(posedge TX_clk); #1;
    Data_Valid = 1'b0;
    repeat (5) @(posedge TX_clk);
    #1;
    @(negedge TX_clk);
    checkOutput("rst_pre_busy", busy, 1'b1);
    checkOutput("rst_pre_line_bit4", TX_OUT, 1'b1);
    #2;
    TX_rst = 1'b1;
    #1;
    checkOutput("rst_line", TX_OUT, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_frame_done", frame_done, 1'b0);
    checkOutput("rst_state_idle", (dut.state == IDLE), 1'b1);
    @(posedge TX_clk); #1;
    TX_rst = 1'b0;
    applyStimulus(8'hF0, 1'b0, 1'b0, {1'b0, 1'b1, 8'hF0, 1'b0}, 10, -1);

    // Long idle with nothing in the FIFO.
    $display("[TB] idle hold");
    Data_Valid = 1'b0;
    P_DATA = 8'h5A;
    for (int i = 0; i < 50; i++) begin
      @(negedge TX_clk);
      checkOutput($sformatf("idle_line[%0d]", i), TX_OUT, 1'b1);
      checkOutput($sformatf("idle_rd_inc[%0d]", i), rd_inc, 1'b0);
      checkOutput($sformatf("idle_busy[%0d]", i), busy, 1'b0);
      checkOutput($sformatf("idle_done[%0d]", i), frame_done, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_uart_tx_frame

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serializing UART transmitter for the system's outbound path: pops one byte at a time from the TX-side FIFO and drives a start/data/parity/stop frame onto TX_OUT at one bit per TX_clk cycle. It is the transmitting counterpart of the system's UART receiver and uses the same frame format, taking parity enable and type from register-file REG2. TX_clk is the prescaled UART bit clock produced by the clock divider, so the block itself has no oversampling.

## Interface
Parameters:
- DW, 8, data byte width; frame carries DW data bits.

Ports:
- TX_clk  in  1  bit-rate clock; all state updates on the rising edge.
- TX_rst  in  1  asynchronous, active-high reset.
- P_DATA  in  DW  byte at the FIFO read port; valid whenever Data_Valid=1.
- Data_Valid  in  1  FIFO not-empty, already synchronized to TX_clk.
- PAR_EN  in  1  parity bit enable (REG2[0]).
- PAR_TYP  in  1  0 = even, 1 = odd (REG2[1]).
- rd_inc  out  1  one-cycle FIFO pop strobe, issued when a byte is accepted.
- TX_OUT  out  1  serial line; idles at 1.
- busy  out  1  high while a frame is on the line.
- frame_done  out  1  one-cycle pulse during the last stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP; 2-state encoding is not allowed; use 3-bit binary encoding.
- IDLE: TX_OUT=1, busy=0. If Data_Valid=1, latch P_DATA, PAR_EN and PAR_TYP, compute the parity bit, pulse rd_inc, and go to START.
- START: TX_OUT=0, then go to DATA with bit_cnt=0.
- DATA: TX_OUT=data[bit_cnt], LSB first. bit_cnt is $clog2(DW) bits wide. At bit_cnt=DW-1, go to PARITY if the latched PAR_EN=1, otherwise go to STOP.
- PARITY: TX_OUT = ^data when the latched PAR_TYP=0 (even), ~^data when it is 1 (odd). Then go to STOP.
- STOP: TX_OUT=1 and frame_done=1. If Data_Valid=1, latch the next byte, pulse rd_inc, and go straight to START, so there is no idle bit between frames. Otherwise go to IDLE.
- Configuration is sampled only at byte acceptance. Changes to PAR_EN or PAR_TYP mid-frame do not affect the current frame.
- rd_inc is asserted only in IDLE or STOP, and only with Data_Valid=1. There is never more than one pop per frame.
- Data_Valid dropping mid-frame has no effect. Data_Valid=0 in IDLE means the block stays idle.

## Timing
- Reset values: TX_OUT=1, busy=0, rd_inc=0, frame_done=0, state IDLE, bit_cnt=0, latched data=0. Reset takes effect immediately and asynchronously, including mid-frame; the line returns to 1 without completing the frame.
- All outputs are registered or decoded from registered state only.
- Latency: rd_inc is high in the cycle where Data_Valid is sampled. The start bit appears on TX_OUT from the next edge.
- Frame length: 1+DW+1 = 10 cycles with parity disabled, 11 with parity enabled (DW=8).
- busy is high from the first START cycle through the last STOP cycle. It stays continuously high across back-to-back frames.
- frame_done and rd_inc coincide in the same cycle on a back-to-back frame.

## Structure
- Shared package uart_pkg holds:
  - the state localparams (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4);
  - the parity type constants PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - the idle line level, 1'b1.
- One natural sub-module, uart_parity_calc: combinational DW-bit XOR reduction plus type select. It is reusable by the receiver's parity checker.
- The FSM, bit counter and data/config latches live in uart_tx_frame.

## Test plan
- Parity disabled, P_DATA=8'h12, one Data_Valid pulse:
  - rd_inc is high for 1 cycle.
  - TX_OUT sequence is 0,0,1,0,0,1,0,0,0,1 (10 cycles).
  - busy is high for 10 cycles; frame_done is high in cycle 10.
- Even parity, 8'hFF → parity bit 0 (11-cycle frame). Odd parity, 8'h12 → parity bit 1. Odd parity, 8'h00 → parity bit 1.
- Back-to-back, even parity, FIFO holding 8'hAA then 8'h55:
  - The second start bit immediately follows the first stop bit.
  - busy never drops; there are exactly 2 rd_inc pulses.
- PAR_EN toggled 0→1 during the DATA bits of 8'h3C: that frame stays 10 cycles, and the next frame is 11 cycles.
- TX_rst asserted at DATA bit 4 of 8'hF0:
  - TX_OUT=1, busy=0 and the state is IDLE asynchronously.
  - After release with Data_Valid=1, a fresh frame begins with a new rd_inc.
- Data_Valid held 0 for 50 cycles: TX_OUT stays 1, and rd_inc, busy and frame_done stay 0.
